video_line_writer: RTL and testbench
====================================

Name: video_line_writer

Overview:
- Capture-side producer that feeds the 16-bit, 2048-deep prefetch line FIFO.
- Takes a raw DE/VS RGB888 pixel stream and converts it to RGB565.
- Frame-aligns the stream, writes pixels into the FIFO through its wr_en/wr_vld handshake, and checks line/frame geometry.
- On FIFO backpressure it drops the rest of the frame and resyncs at the next vsync, so the FIFO never takes a partial or misaligned frame start.

Parameters:
- H_ACTIVE, 1280, active pixels per line.
- V_ACTIVE, 720, active lines per frame.
- CNT_W, 12, width of pixel/line counters; must hold H_ACTIVE and V_ACTIVE.

Ports:
- clk  in  1  single system clock; same clock as the FIFO.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; takes effect only at frame boundaries.
- vs_in  in  1  vertical sync, active high.
- de_in  in  1  data enable, active high.
- rgb_in  in  24  {R[7:0],G[7:0],B[7:0]}.
- fifo_wr_vld  in  1  FIFO can accept a write this cycle.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  16  RGB565 pixel.
- frame_start  out  1  1-cycle pulse when a frame is accepted for capture.
- frame_done  out  1  1-cycle pulse after line V_ACTIVE completes.
- line_cnt  out  CNT_W  completed lines in the current frame.
- ovf_cnt  out  8  dropped frames, saturating at 255.
- err_len  out  1  sticky: a line length differed from H_ACTIVE.
- err_short  out  1  sticky: vsync arrived before V_ACTIVE lines.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; counters 0; input pipeline registers 0.
- Input stage: vs_in, de_in and rgb_in are registered once (vs_d, de_d, pix_d); vs_d is registered again for edge detection. vs_rise = vs_d & ~vs_d2.
- Conversion: fifo_wr_data = {R[7:3],G[7:2],B[7:3]} taken from pix_d.
- Write: fifo_wr_en = de_d & (state==ACTIVE) & fifo_wr_vld. The output is combinational from fifo_wr_vld; there is no other combinational path. Latency is 1 cycle from de_in to fifo_wr_en.
- pix_cnt increments on every de_d cycle in ACTIVE, whether or not the write was accepted.
- State machine:
  - IDLE: when enable=1, go to WAIT_VS.
  - WAIT_VS: on vs_rise, clear line_cnt and pix_cnt, pulse frame_start, go to ACTIVE. If enable=0, return to IDLE.
  - ACTIVE:
    - de_d falling edge: line ends. If pix_cnt != H_ACTIVE, set err_len. Then line_cnt+1 and pix_cnt=0.
    - When line_cnt reaches V_ACTIVE: pulse frame_done. Go to WAIT_VS, or to IDLE if enable=0.
    - vs_rise before V_ACTIVE lines: set err_short. Restart the frame in the same cycle (clear counters, pulse frame_start, stay in ACTIVE). If enable=0, go to IDLE instead.
    - de_d=1 with fifo_wr_vld=0: pixel is lost. ovf_cnt+1 (saturating). Go to DROP.
  - DROP: no writes. Ignore de. On vs_rise, behave exactly as WAIT_VS does on vs_rise.
- enable deasserted mid-frame: the current frame completes. IDLE is entered only at frame_done, at a restart point, or from WAIT_VS.
- Lines with de_d active after line V_ACTIVE: not reachable; the FSM has already left ACTIVE.
- Sticky errors clear only on reset.

Optional Feature:
- Macro: VLW_PATTERN_EN.
- Defined:
  - Adds input port pat_en (1 bit).
  - When pat_en=1, fifo_wr_data = (pix_cnt + line_cnt) truncated to 16 bits, using counter values before increment. This produces a diagonal ramp for checking the DDR/display path.
  - Handshake, FSM and errors are unchanged.
- Undefined: no pat_en port; data is always converted RGB565.

Test Plan:
Benches use H_ACTIVE=8, V_ACTIVE=4.
- Nominal frame: enable=1, vs pulse, then 4 lines of 8 DE cycles with rgb_in=24'hFF8040 and fifo_wr_vld=1. Expect 32 fifo_wr_en with data 16'hFC08, 1 frame_start, 1 frame_done, line_cnt=4, no errors.
- Backpressure: fifo_wr_vld=0 on the 3rd pixel of line 2. Expect 10 writes total, ovf_cnt=1, no further writes until the next vs. The next frame gives 32 writes.
- Short line: line 1 has 7 DE cycles. Expect err_len=1 after that line, frame_done still asserted after line 4, err_len held across later frames.
- Early vsync: vs arrives after 2 lines. Expect err_short=1, a frame_start pulse, line_cnt=0, and the following 4 lines captured normally.
- Enable timing / reset: enable=0 mid-frame leaves the frame complete then IDLE; vs is then ignored. rst low mid-line immediately gives fifo_wr_en=0 and all counters 0.
- With VLW_PATTERN_EN: pat_en=1. Line 1 data is 1..8 and line 3 data is 3..10.

Source files
------------

// File: rtl/video_line_writer.sv
// Capture-side producer for the 16-bit prefetch line FIFO.
// It takes a DE/VS RGB888 stream and writes frame-aligned RGB565 pixels.
// It checks line length and frame height, and drops the rest of a frame on
// FIFO backpressure.
// Ports: clk, rst (async active-low), enable, vs_in, de_in, rgb_in,
//   fifo_wr_vld in; fifo_wr_en, fifo_wr_data out; status frame_start,
//   frame_done, line_cnt, ovf_cnt, err_len, err_short.
// Option: define VLW_PATTERN_EN to add pat_en, which selects a diagonal
//   test ramp (pix_cnt + line_cnt) instead of the video data.
module video_line_writer #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             vs_in,
    input  logic             de_in,
    input  logic [23:0]      rgb_in,
`ifdef VLW_PATTERN_EN
    input  logic             pat_en,
`endif
    input  logic             fifo_wr_vld,
    output logic             fifo_wr_en,
    output logic [15:0]      fifo_wr_data,
    output logic             frame_start,
    output logic             frame_done,
    output logic [CNT_W-1:0] line_cnt,
    output logic [7:0]       ovf_cnt,
    output logic             err_len,
    output logic             err_short
);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DROP} state_t;

    localparam logic [CNT_W-1:0] H_LEN = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LEN = CNT_W'(V_ACTIVE);

    state_t           state;
    logic             vs_d;
    logic             vs_d2;
    logic             de_d;
    logic             de_d2;
    logic [23:0]      pix_d;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_nxt;
    logic [15:0]      rgb565;
    logic             vs_rise;
    logic             line_end;
    logic             unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_d  <= 1'b0;
            vs_d2 <= 1'b0;
            de_d  <= 1'b0;
            de_d2 <= 1'b0;
            pix_d <= '0;
        end else begin
            vs_d  <= vs_in;
            vs_d2 <= vs_d;
            de_d  <= de_in;
            de_d2 <= de_d;
            pix_d <= rgb_in;
        end
    end

    assign vs_rise  = vs_d & ~vs_d2;
    assign line_end = de_d2 & ~de_d;
    assign line_nxt = line_cnt + 1'b1;

    assign rgb565 = {pix_d[23:19], pix_d[15:10], pix_d[7:3]};
    assign unused_bits = ^{pix_d[18:16], pix_d[9:8], pix_d[2:0]};

    // Only the FIFO ready is combinational; everything else is registered.
    assign fifo_wr_en = de_d & (state == ACTIVE) & fifo_wr_vld;

`ifdef VLW_PATTERN_EN
    logic [15:0] ramp;
    assign ramp = 16'(pix_cnt) + 16'(line_cnt);
    assign fifo_wr_data = pat_en ? ramp : rgb565;
`else
    assign fifo_wr_data = rgb565;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            ovf_cnt     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_len     <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) state <= WAIT_VS;
                end
                WAIT_VS, DROP: begin
                    // DROP ignores de and waits for vsync like WAIT_VS,
                    // but it stays committed to the dropped frame until then.
                    if (state == WAIT_VS && !enable) begin
                        state <= IDLE;
                    end else if (vs_rise) begin
                        pix_cnt     <= '0;
                        line_cnt    <= '0;
                        frame_start <= enable;
                        state       <= enable ? ACTIVE : IDLE;
                    end
                end
                ACTIVE: begin
                    if (vs_rise) begin
                        // The frame was short: restart it on this vsync.
                        err_short   <= 1'b1;
                        pix_cnt     <= '0;
                        line_cnt    <= '0;
                        frame_start <= enable;
                        if (!enable) state <= IDLE;
                    end else if (line_end) begin
                        if (pix_cnt != H_LEN) err_len <= 1'b1;
                        line_cnt <= line_nxt;
                        pix_cnt  <= '0;
                        if (line_nxt == V_LEN) begin
                            frame_done <= 1'b1;
                            state      <= enable ? WAIT_VS : IDLE;
                        end
                    end else if (de_d) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (!fifo_wr_vld) begin
                            if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
                            state <= DROP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_line_writer.sv
// Self-checking bench for video_line_writer (H_ACTIVE=8, V_ACTIVE=4).
// Directed table of frames, hand sequences, then randomized frames vs a model.
module tb_video_line_writer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          vs_in = 1'b0;
    logic          de_in = 1'b0;
    logic [23:0]   rgb_in = '0;
    logic          fifo_wr_vld = 1'b1;
`ifdef VLW_PATTERN_EN
    logic          pat_en = 1'b0;
`endif
    logic          fifo_wr_en;
    logic [15:0]   fifo_wr_data;
    logic          frame_start;
    logic          frame_done;
    logic [CW-1:0] line_cnt;
    logic [7:0]    ovf_cnt;
    logic          err_len;
    logic          err_short;

    video_line_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .vs_in(vs_in),
        .de_in(de_in),
        .rgb_in(rgb_in),
`ifdef VLW_PATTERN_EN
        .pat_en(pat_en),
`endif
        .fifo_wr_vld(fifo_wr_vld),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .frame_start(frame_start),
        .frame_done(frame_done),
        .line_cnt(line_cnt),
        .ovf_cnt(ovf_cnt),
        .err_len(err_len),
        .err_short(err_short)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int nwr = 0;
    int nfs = 0;
    int nfd = 0;
    logic [15:0] got[$];
    logic [15:0] expq[$];
    logic [23:0] pix [4][10];

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            nwr++;
            got.push_back(fifo_wr_data);
        end
        if (frame_start) nfs++;
        if (frame_done) nfd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    // Abstract model state: is a frame being captured, sticky flags.
    bit m_active = 0;
    bit m_el = 0;
    bit m_es = 0;
    bit m_pat = 0;
    int m_ovf = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to565(input logic [23:0] c);
        int r, g, b;
        r = int'(c[23:16]);
        g = int'(c[15:8]);
        b = int'(c[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    // One frame: vsync, blanking, nl lines of lens[l] pixels.
    // The FIFO refuses the pixel (sl,sp); enable drops after line dis.
    task automatic play_frame(input int nl, input int lens[4], input int sl,
                              input int sp, input bit rnd, input int dis,
                              output logic [CW-1:0] lc0);
        vs_in = 1'b1;
        tick();
        tick();
        vs_in = 1'b0;
        repeat (4) tick();
        lc0 = line_cnt;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < lens[l]; p++) begin
                de_in = 1'b1;
                rgb_in = rnd ? 24'($urandom) : 24'hFF8040;
                pix[l][p] = rgb_in;
                tick();
                fifo_wr_vld = !(l == sl && p == sp);
            end
            de_in = 1'b0;
            rgb_in = '0;
            tick();
            fifo_wr_vld = 1'b1;
            repeat (3) tick();
            if (l == dis) enable = 1'b0;
        end
        repeat (4) tick();
    endtask

    // Expected writes and status from the frame description alone.
    task automatic model_frame(input int nl, input int lens[4], input int sl,
                               input int sp, output int e_fd, output int e_lc);
        bit stalled;
        int done;
        stalled = 0;
        done = 0;
        e_fd = 0;
        expq.delete();
        if (m_active) m_es = 1;
        for (int l = 0; l < nl && !stalled; l++) begin
            for (int p = 0; p < lens[l] && !stalled; p++) begin
                if (l == sl && p == sp) begin
                    stalled = 1;
                    if (m_ovf < 255) m_ovf++;
                end else begin
                    expq.push_back(m_pat ? 16'(l + p) : to565(pix[l][p]));
                end
            end
            if (!stalled) begin
                if (lens[l] != H) m_el = 1;
                done++;
            end
        end
        m_active = !stalled && (done < V);
        if (!stalled && done == V) e_fd = 1;
        e_lc = done;
    endtask

    task automatic run_model_frame(input int nl, input int lens[4],
                                   input int sl, input int sp);
        int b_wr, b_fs, b_fd, g0, e_fd, e_lc, bad;
        logic [CW-1:0] lc0;
        b_wr = nwr;
        b_fs = nfs;
        b_fd = nfd;
        g0 = got.size();
        play_frame(nl, lens, sl, sp, 1'b1, -1, lc0);
        model_frame(nl, lens, sl, sp, e_fd, e_lc);
        bad = 0;
        foreach (expq[k])
            if (g0 + k >= got.size() || got[g0 + k] !== expq[k]) bad++;
        chk("rnd_writes", nwr - b_wr, expq.size());
        chk("rnd_data_bad", bad, 0);
        chk("rnd_frame_start", nfs - b_fs, 1);
        chk("rnd_start_line_cnt", lc0, 0);
        chk("rnd_frame_done", nfd - b_fd, e_fd);
        chk("rnd_line_cnt", line_cnt, e_lc);
        chk("rnd_ovf", ovf_cnt, m_ovf);
        chk("rnd_errs", {err_len, err_short}, {m_el, m_es});
    endtask

    typedef struct {
        int nl; int l1; int sl; int sp;
        int wr; int fs; int fd; int lc; int ovf; bit el; bit es;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int lens[4];
        int b_wr, b_fs, b_fd, g0, bad;
        logic [CW-1:0] lc0;

        tbl[0] = '{4, 8, -1, -1, 32, 1, 1, 4, 0, 0, 0};
        tbl[1] = '{4, 8,  1,  2, 10, 1, 0, 1, 1, 0, 0};
        tbl[2] = '{4, 8, -1, -1, 32, 1, 1, 4, 1, 0, 0};
        tbl[3] = '{4, 7, -1, -1, 31, 1, 1, 4, 1, 1, 0};
        tbl[4] = '{4, 8, -1, -1, 32, 1, 1, 4, 1, 1, 0};
        tbl[5] = '{2, 8, -1, -1, 16, 1, 0, 2, 1, 1, 0};
        tbl[6] = '{4, 8, -1, -1, 32, 1, 1, 4, 1, 1, 1};

        repeat (3) tick();
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_flags", {err_len, err_short, frame_start, frame_done}, 0);
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 7; i++) begin
            lens = '{8, tbl[i].l1, 8, 8};
            b_wr = nwr;
            b_fs = nfs;
            b_fd = nfd;
            g0 = got.size();
            play_frame(tbl[i].nl, lens, tbl[i].sl, tbl[i].sp, 1'b0, -1, lc0);
            bad = 0;
            for (int k = g0; k < got.size(); k++)
                if (got[k] !== 16'hFC08) bad++;
            chk($sformatf("t%0d_writes", i), nwr - b_wr, tbl[i].wr);
            chk($sformatf("t%0d_data_bad", i), bad, 0);
            chk($sformatf("t%0d_frame_start", i), nfs - b_fs, tbl[i].fs);
            chk($sformatf("t%0d_start_line_cnt", i), lc0, 0);
            chk($sformatf("t%0d_frame_done", i), nfd - b_fd, tbl[i].fd);
            chk($sformatf("t%0d_line_cnt", i), line_cnt, tbl[i].lc);
            chk($sformatf("t%0d_ovf", i), ovf_cnt, tbl[i].ovf);
            chk($sformatf("t%0d_err_len", i), err_len, tbl[i].el);
            chk($sformatf("t%0d_err_short", i), err_short, tbl[i].es);
        end

        // Enable dropped after line 0: frame still completes, then vs ignored.
        lens = '{8, 8, 8, 8};
        b_wr = nwr;
        b_fd = nfd;
        play_frame(4, lens, -1, -1, 1'b0, 0, lc0);
        chk("en_off_writes", nwr - b_wr, 32);
        chk("en_off_frame_done", nfd - b_fd, 1);
        b_wr = nwr;
        b_fs = nfs;
        play_frame(4, lens, -1, -1, 1'b0, -1, lc0);
        chk("idle_writes", nwr - b_wr, 0);
        chk("idle_frame_start", nfs - b_fs, 0);
        chk("idle_line_cnt", line_cnt, 4);
        enable = 1'b1;
        repeat (3) tick();

        // Asynchronous reset in the middle of line 1.
        vs_in = 1'b1;
        tick();
        tick();
        vs_in = 1'b0;
        repeat (4) tick();
        de_in = 1'b1;
        rgb_in = 24'hFF8040;
        repeat (8) tick();
        de_in = 1'b0;
        repeat (4) tick();
        de_in = 1'b1;
        repeat (3) tick();
        chk("pre_rst_wr_en", fifo_wr_en, 1);
        chk("pre_rst_line_cnt", line_cnt, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_wr_en", fifo_wr_en, 0);
        chk("mid_rst_line_cnt", line_cnt, 0);
        chk("mid_rst_ovf", ovf_cnt, 0);
        chk("mid_rst_errs", {err_len, err_short}, 0);
        de_in = 1'b0;
        rgb_in = '0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        m_active = 0;
        m_el = 0;
        m_es = 0;
        m_ovf = 0;

        for (int f = 0; f < 14; f++) begin
            int nl, sl, sp;
            nl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 3)) : 4;
            for (int l = 0; l < 4; l++) begin
                lens[l] = 8;
                if ($urandom_range(0, 5) == 0) lens[l] = $urandom_range(0, 1) ? 7 : 9;
            end
            sl = -1;
            sp = -1;
            if ($urandom_range(0, 2) == 0) begin
                sl = $urandom_range(0, nl - 1);
                sp = $urandom_range(0, lens[sl] - 1);
            end
            run_model_frame(nl, lens, sl, sp);
        end

`ifdef VLW_PATTERN_EN
        pat_en = 1'b1;
        m_pat = 1;
        lens = '{8, 8, 8, 8};
        g0 = got.size();
        run_model_frame(4, lens, -1, -1);
        chk("pat_line1_first", got[g0 + 8], 1);
        chk("pat_line3_last", got[g0 + 31], 10);
        pat_en = 1'b0;
        m_pat = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
